enable_sequencer: RTL and testbench

Parametrised, single-clock generator of staggered channel enables. A trigger edge turns on all `N_CH` enables together. The enables then release one at a time, in a selectable order, each phase lasting a programmable number of cycles. The block generalises the fixed 3-channel trigger/enable counter: it adds a programmable phase length, release direction, abort, busy/done status and retrigger error reporting. It sits between the trigger logic and the per-channel gated datapaths.

---
 rtl/enable_sequencer.sv | 135 +++++++++++++
 tb/tb_enable_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/enable_sequencer.sv
// Staggered channel-enable sequencer: a trigger edge raises all enables at once,
// then the channels drop one per phase in the latched order.
module enable_sequencer #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trg,
  input  logic              abort,
  input  logic              mode,
  input  logic [HOLD_W-1:0] hold,
  output logic [N_CH-1:0]   ena,
  output logic              busy,
  output logic              ack,
  output logic              done,
  output logic              retrig_err
);

  localparam int unsigned PhW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PhW-1:0] LastPh = PhW'(N_CH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mode_q, mode_d;
  logic              trg_q;
  logic [N_CH-1:0]   ena_q, ena_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              trg_edge;

  // Channels still enabled during phase p for the given release order.
  function automatic logic [N_CH-1:0] pattern(input logic m, input logic [PhW-1:0] p);
    int unsigned ip;
    ip = 32'(p);
    for (int unsigned i = 0; i < N_CH; i++) begin
      pattern[i] = m ? (i + ip <= N_CH - 1) : (i >= ip);
    end
  endfunction

  assign trg_edge = trg & ~trg_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    ena_d   = ena_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        ena_d  = '0;
        busy_d = 1'b0;
        if (trg_edge && !abort) begin
          hold_d  = hold;
          mode_d  = mode;
          phase_d = '0;
          cnt_d   = hold;
          ena_d   = '1;
          busy_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (trg_edge) err_d = 1'b1;
        if (abort) begin
          ena_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          if (phase_q == LastPh) begin
            ena_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            phase_d = phase_q + PhW'(1);
            cnt_d   = hold_q;
            ena_d   = pattern(mode_q, phase_q + PhW'(1));
          end
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // trg_q resets high so a level held through reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      mode_q  <= 1'b0;
      trg_q   <= 1'b1;
      ena_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      trg_q   <= trg;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ena        = ena_q;
  assign busy       = busy_q;
  assign ack        = ack_q;
  assign done       = done_q;
  assign retrig_err = err_q;

endmodule

// File: tb/tb_enable_sequencer.sv
// Bench for enable_sequencer: timeline-based reference model checked every cycle,
// plus directed literal checks of the documented scenarios.
module tb_enable_sequencer;

  localparam int N = 3;
  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          rst, trg, abort, mode;
  logic [HW-1:0] hold;
  logic [N-1:0]  ena;
  logic          busy, ack, done, retrig_err;

  int errors = 0;
  int checks = 0;

  enable_sequencer #(.N_CH(N), .HOLD_W(HW)) dut (
    .clk        (clk),
    .rst        (rst),
    .trg        (trg),
    .abort      (abort),
    .mode       (mode),
    .hold       (hold),
    .ena        (ena),
    .busy       (busy),
    .ack        (ack),
    .done       (done),
    .retrig_err (retrig_err)
  );

  always #5 clk = ~clk;

  // Reference model: remembers the acceptance edge and derives the phase from
  // elapsed edges, so outputs follow directly from the timeline rules.
  int           cyc = 0;
  int           m_k = 0;
  int           m_h = 0;
  logic         m_mode = 1'b0;
  logic         m_active = 1'b0;
  logic         m_trg_prev = 1'b1;
  logic         m_valid = 1'b0;
  logic [N-1:0] e_ena = '0;
  logic         e_busy = 1'b0, e_ack = 1'b0, e_done = 1'b0, e_err = 1'b0;

  function automatic logic [N-1:0] model_pat(input logic m, input int p);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m ? (i <= N - 1 - p) : (i >= p);
    return r;
  endfunction

  always @(posedge clk) begin
    int  off;
    logic edge_seen;
    if (rst) begin
      m_active = 1'b0; m_trg_prev = 1'b1; m_valid = 1'b1;
      e_ena = '0; e_busy = 1'b0; e_ack = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      edge_seen = trg && !m_trg_prev;
      m_trg_prev = trg;
      e_ack = 1'b0;
      e_done = 1'b0;
      if (m_active) begin
        if (edge_seen) e_err = 1'b1;
        off = cyc - m_k;
        if (abort) begin
          m_active = 1'b0; e_ena = '0; e_busy = 1'b0;
        end else if (off == N * (m_h + 1)) begin
          m_active = 1'b0; e_ena = '0; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          e_ena = model_pat(m_mode, off / (m_h + 1));
        end
      end else begin
        e_ena = '0; e_busy = 1'b0;
        if (edge_seen && !abort) begin
          m_active = 1'b1; m_k = cyc; m_h = int'(hold); m_mode = mode;
          e_ena = '1; e_busy = 1'b1; e_ack = 1'b1;
        end
      end
    end
    cyc++;
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_ena", int'(ena), int'(e_ena));
      cmp("model_busy", int'(busy), int'(e_busy));
      cmp("model_ack", int'(ack), int'(e_ack));
      cmp("model_done", int'(done), int'(e_done));
      cmp("model_err", int'(retrig_err), int'(e_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; trg = 1'b0; abort = 1'b0; mode = 1'b0; hold = '0;
    step(); step();
    cmp("reset_ena", int'(ena), 0);
    cmp("reset_err", int'(retrig_err), 0);
    rst = 1'b0;
    step();

    // Basic sequence, hold=0, mode=0
    trg = 1'b1; step();
    cmp("basic_k_ena", int'(ena), 'b111);
    cmp("basic_k_ack", int'(ack), 1);
    trg = 1'b0; step();
    cmp("basic_k1_ena", int'(ena), 'b110);
    step();
    cmp("basic_k2_ena", int'(ena), 'b100);
    step();
    cmp("basic_k3_ena", int'(ena), 'b000);
    cmp("basic_k3_done", int'(done), 1);
    cmp("basic_k3_busy", int'(busy), 0);
    step();

    // hold=2, hold changed mid-run
    hold = 4'd2; trg = 1'b1; step();
    trg = 1'b0; hold = 4'd5;
    repeat (2) step();
    cmp("hold_k2_ena", int'(ena), 'b111);
    step();
    cmp("hold_k3_ena", int'(ena), 'b110);
    repeat (5) step();
    cmp("hold_k8_ena", int'(ena), 'b100);
    step();
    cmp("hold_k9_done", int'(done), 1);
    step();

    // mode=1
    hold = '0; mode = 1'b1; trg = 1'b1; step();
    trg = 1'b0; mode = 1'b0; step();
    cmp("mode1_k1_ena", int'(ena), 'b011);
    step();
    cmp("mode1_k2_ena", int'(ena), 'b001);
    step();
    cmp("mode1_k3_done", int'(done), 1);
    step();

    // Retrigger during phase 1, then retrigger in the done cycle
    trg = 1'b1; step();
    trg = 1'b0; step();
    trg = 1'b1; step();
    cmp("retrig_err", int'(retrig_err), 1);
    cmp("retrig_ena", int'(ena), 'b100);
    trg = 1'b0; step();
    cmp("retrig_done", int'(done), 1);
    trg = 1'b1; step();
    cmp("retrig_done_cycle_ack", int'(ack), 1);
    cmp("retrig_err_sticky", int'(retrig_err), 1);
    trg = 1'b0; repeat (4) step();

    // Trigger at the completion edge is not accepted
    trg = 1'b1; step();
    trg = 1'b0; repeat (2) step();
    trg = 1'b1; step();
    cmp("compl_edge_done", int'(done), 1);
    cmp("compl_edge_ack", int'(ack), 0);
    step();
    cmp("compl_edge_noack", int'(ack), 0);
    trg = 1'b0; step();

    // Abort in phase 1 with hold=3
    hold = 4'd3; trg = 1'b1; step();
    trg = 1'b0; repeat (4) step();
    cmp("abort_ph1_ena", int'(ena), 'b110);
    abort = 1'b1; step();
    cmp("abort_ena", int'(ena), 0);
    cmp("abort_busy", int'(busy), 0);
    abort = 1'b0; repeat (12) step();
    abort = 1'b1; trg = 1'b1; step();
    cmp("abort_idle_ack", int'(ack), 0);
    abort = 1'b0; trg = 1'b0; step();

    // trg held through reset, then reset mid-sequence
    rst = 1'b1; trg = 1'b1; repeat (2) step();
    rst = 1'b0; step();
    cmp("rst_held_ack", int'(ack), 0);
    trg = 1'b0; step();
    trg = 1'b1; step();
    cmp("rst_rerise_ack", int'(ack), 1);
    trg = 1'b0; step();
    rst = 1'b1; step();
    cmp("rst_mid_ena", int'(ena), 0);
    cmp("rst_mid_busy", int'(busy), 0);
    rst = 1'b0; hold = '0; step();

    // Randomized stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      rst   = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 3) == 0) trg = ~trg;
      abort = ($urandom_range(0, 49) == 0);
      mode  = 1'($urandom);
      hold  = ($urandom_range(0, 9) == 0) ? HW'($urandom) : HW'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; trg = 1'b0; abort = 1'b0;
    repeat (60) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
